port_rx_checker: RTL and testbench
==================================

// Module: port_rx_checker
// PURPOSE
//  Receive-side packet sink/checker attached to one switch output port (port<N>_rd_* stream).
//  Consumes sop/eop/vld/data beats, parses the header byte: [7:4] priority, [3:0] destination port.
//  Checks destination, length and the incrementing payload pattern produced by our port packet sources.
//  Reports a per-packet result and keeps saturating statistics. Used in system sims and on-chip self-test.
// PARAMETERS
//  PORT_ID        0     destination value this port must receive (header[3:0])
//  MIN_LEN        2     minimum legal packet length in bytes, header included
//  MAX_LEN        1024  maximum legal packet length in bytes, header included (<= 4095)
//  CNT_W          16    width of statistics counters
//  CHECK_PATTERN  1     1 = check payload pattern, 0 = skip data check
// PORTS
//  sys_clk     in   1      clock
//  sys_rst     in   1      asynchronous reset, active-high
//  rd_sop      in   1      start of packet; qualified by rd_vld
//  rd_eop      in   1      end of packet; qualified by rd_vld
//  rd_vld      in   1      data beat valid
//  rd_data     in   8      byte; the sop beat is the header
//  clr_stats   in   1      synchronous clear of good_cnt/bad_cnt/orphan_cnt
//  busy        out  1      1 while inside a packet (state != IDLE)
//  pkt_done    out  1      one-cycle pulse: packet result valid
//  pkt_ok      out  1      pkt_err == 0; valid with pkt_done, held until the next pkt_done
//  pkt_pri     out  4      header[7:4] of the finished packet
//  pkt_dest    out  4      header[3:0] of the finished packet
//  pkt_len     out  12     bytes received, header included
//  pkt_err     out  5      [0]DEST [1]DATA [2]SHORT [3]LONG [4]TRUNC
//  good_cnt    out  CNT_W  packets with pkt_ok=1, saturating
//  bad_cnt     out  CNT_W  packets with pkt_ok=0, saturating
//  orphan_cnt  out  CNT_W  vld beats outside a packet, saturating
// BEHAVIOUR
//  - Reset: all outputs 0; FSM = IDLE. Reset mid-packet discards the partial packet; no pkt_done is issued.
//  - A beat is a cycle with rd_vld=1. rd_sop/rd_eop/rd_data are ignored when rd_vld=0.
//    vld gaps inside a packet are legal.
//  - FSM IDLE / BODY / DRAIN:
//    IDLE : sop beat -> latch header; len=1; exp=0x00; DEST set if header[3:0] != PORT_ID; go to BODY.
//           sop+eop on the same beat finishes a 1-byte packet and stays in IDLE.
//           Non-sop beat -> orphan_cnt++; stay in IDLE.
//    BODY : each beat: len++. If CHECK_PATTERN and data != exp, set DATA. exp <= exp+1 (mod 256, wraps)
//           regardless of data. eop beat -> finish; go to IDLE.
//           Beat that would make len > MAX_LEN -> set LONG; len holds MAX_LEN; go to DRAIN.
//    DRAIN: count nothing; eop beat -> finish; go to IDLE.
//    BODY/DRAIN with a sop beat: finish the current packet with TRUNC set (sop byte not counted in it).
//           In the same cycle, start the new packet from that beat exactly as IDLE does.
//  - Finish: SHORT set if len < MIN_LEN. Result regs and pkt_done=1 appear on the clock after the eop beat.
//    Latency is 1 cycle.
//  - Stats: good_cnt/bad_cnt update together with pkt_done; all counters saturate at all-ones.
//    clr_stats has priority: a packet finishing in the clr cycle is not counted.
//  - Byte k of a packet (k>=1) is expected to be (k-1) mod 256.
// TESTING
//  1 PORT_ID=1: sop hdr 0x11, then 0x00..0x41, eop on 0x41 (67 beats)
//    -> 1 cycle later pkt_done, len=67, pri=1, dest=1, err=0, good_cnt=1.
//  2 hdr 0x32 with a valid payload, PORT_ID=1 -> err=5'b00001, bad_cnt=1, good_cnt unchanged.
//  3 Byte index 20 forced to 0xFF; vld dropped 3 cycles mid-packet
//    -> err=5'b00010, len=67 (gaps not counted), bytes after index 20 still pass.
//  4 New sop arrives on byte index 30 of packet A
//    -> A: len=30, err=5'b10000; B completes normally with err=0.
//  5 MAX_LEN=256, 300-byte packet (payload wraps 0xFF->0x00)
//    -> DRAIN entered, err=5'b01000, len=256.
//    sop+eop single beat -> len=1, err=5'b00100.
//  6 5 vld beats with no sop -> orphan_cnt=5.
//    sys_rst pulsed mid-packet -> no pkt_done; all counters 0.
//    clr_stats in the pkt_done cycle -> counters 0.

Source files
------------

// File: rtl/port_rx_checker.sv
// Receive-side packet checker for one switch output port: parses the header, checks dest/length/payload pattern.
// Latency: per-packet result and pkt_done appear one clock after the eop beat.
// Backpressure: none; every rd_vld beat is consumed in the cycle it arrives.
module port_rx_checker #(
  parameter int PORT_ID       = 0,
  parameter int MIN_LEN       = 2,
  parameter int MAX_LEN       = 1024,
  parameter int CNT_W         = 16,
  parameter int CHECK_PATTERN = 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             rd_sop,
  input  logic             rd_eop,
  input  logic             rd_vld,
  input  logic [7:0]       rd_data,
  input  logic             clr_stats,
  output logic             busy,
  output logic             pkt_done,
  output logic             pkt_ok,
  output logic [3:0]       pkt_pri,
  output logic [3:0]       pkt_dest,
  output logic [11:0]      pkt_len,
  output logic [4:0]       pkt_err,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt,
  output logic [CNT_W-1:0] orphan_cnt
);

  // Error flag bit positions
  localparam int E_DEST  = 0;
  localparam int E_DATA  = 1;
  localparam int E_SHORT = 2;
  localparam int E_LONG  = 3;
  localparam int E_TRUNC = 4;

  localparam logic [3:0]  PORT_L = 4'(PORT_ID);
  localparam logic [11:0] MIN_L  = 12'(MIN_LEN);
  localparam logic [11:0] MAX_L  = 12'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BODY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  hdr_q, hdr_d;
  logic [11:0] len_q, len_d;
  logic [7:0]  exp_q, exp_d;
  logic [4:0]  acc_q, acc_d;

  logic        done_q, done_d;
  logic        ok_q, ok_d;
  logic [7:0]  res_hdr_q, res_hdr_d;
  logic [11:0] res_len_q, res_len_d;
  logic [4:0]  res_err_q, res_err_d;

  logic [CNT_W-1:0] good_q, good_d;
  logic [CNT_W-1:0] bad_q, bad_d;
  logic [CNT_W-1:0] orphan_q, orphan_d;

  // Packet finish / start / orphan events for the current beat
  logic        fin;
  logic        start;
  logic        orphan;
  logic [7:0]  fin_hdr;
  logic [11:0] fin_len;
  logic [4:0]  fin_err;

  // Packet parsing FSM: next state, running packet context and the finishing packet's result.
  // A sop inside a packet closes the old one as TRUNC and opens the new one in the same cycle.
  // If that sop also carries eop, the truncated packet owns the single result slot and the
  // 1-byte packet is discarded; the FSM returns to IDLE.
  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    len_d   = len_q;
    exp_d   = exp_q;
    acc_d   = acc_q;
    fin     = 1'b0;
    start   = 1'b0;
    orphan  = 1'b0;
    fin_hdr = hdr_q;
    fin_len = len_q;
    fin_err = acc_q;

    case (state_q)
      IDLE: begin
        if (rd_vld) begin
          if (rd_sop) start = 1'b1;
          else        orphan = 1'b1;
        end
      end
      BODY: begin
        if (rd_vld) begin
          if (rd_sop) begin
            fin            = 1'b1;
            fin_err[E_TRUNC] = 1'b1;
            start          = 1'b1;
          end else if (len_q == MAX_L) begin
            // Beat past the maximum: length stays clamped, rest of packet is drained
            acc_d[E_LONG] = 1'b1;
            if (rd_eop) begin
              fin             = 1'b1;
              fin_err[E_LONG] = 1'b1;
              state_d         = IDLE;
            end else begin
              state_d = DRAIN;
            end
          end else begin
            len_d = len_q + 12'd1;
            exp_d = exp_q + 8'd1;
            if ((CHECK_PATTERN != 0) && (rd_data != exp_q)) acc_d[E_DATA] = 1'b1;
            if (rd_eop) begin
              fin     = 1'b1;
              fin_len = len_d;
              fin_err = acc_d;
              state_d = IDLE;
            end
          end
        end
      end
      DRAIN: begin
        if (rd_vld) begin
          if (rd_sop) begin
            fin              = 1'b1;
            fin_err[E_TRUNC] = 1'b1;
            start            = 1'b1;
          end else if (rd_eop) begin
            fin     = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      hdr_d         = rd_data;
      len_d         = 12'd1;
      exp_d         = 8'h00;
      acc_d         = '0;
      acc_d[E_DEST] = (rd_data[3:0] != PORT_L);
      if (rd_eop) begin
        if (!fin) begin
          fin     = 1'b1;
          fin_hdr = rd_data;
          fin_len = 12'd1;
          fin_err = acc_d;
        end
        state_d = IDLE;
      end else begin
        state_d = BODY;
      end
    end

    if (fin && (fin_len < MIN_L)) fin_err[E_SHORT] = 1'b1;
  end

  // Result registers and saturating statistics; clr_stats overrides any same-cycle update
  always_comb begin
    done_d    = fin;
    ok_d      = ok_q;
    res_hdr_d = res_hdr_q;
    res_len_d = res_len_q;
    res_err_d = res_err_q;
    good_d    = good_q;
    bad_d     = bad_q;
    orphan_d  = orphan_q;

    if (fin) begin
      ok_d      = (fin_err == 5'd0);
      res_hdr_d = fin_hdr;
      res_len_d = fin_len;
      res_err_d = fin_err;
    end

    if (clr_stats) begin
      good_d   = '0;
      bad_d    = '0;
      orphan_d = '0;
    end else begin
      if (fin && (fin_err == 5'd0) && (good_q != CNT_MAX)) good_d = good_q + 1'b1;
      if (fin && (fin_err != 5'd0) && (bad_q != CNT_MAX))  bad_d  = bad_q + 1'b1;
      if (orphan && (orphan_q != CNT_MAX))                 orphan_d = orphan_q + 1'b1;
    end
  end

  // State and packet-context registers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      hdr_q   <= '0;
      len_q   <= '0;
      exp_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      len_q   <= len_d;
      exp_q   <= exp_d;
      acc_q   <= acc_d;
    end
  end

  // Result and counter registers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
      res_hdr_q <= '0;
      res_len_q <= '0;
      res_err_q <= '0;
      good_q    <= '0;
      bad_q     <= '0;
      orphan_q  <= '0;
    end else begin
      done_q    <= done_d;
      ok_q      <= ok_d;
      res_hdr_q <= res_hdr_d;
      res_len_q <= res_len_d;
      res_err_q <= res_err_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
      orphan_q  <= orphan_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign pkt_done   = done_q;
  assign pkt_ok     = ok_q;
  assign pkt_pri    = res_hdr_q[7:4];
  assign pkt_dest   = res_hdr_q[3:0];
  assign pkt_len    = res_len_q;
  assign pkt_err    = res_err_q;
  assign good_cnt   = good_q;
  assign bad_cnt    = bad_q;
  assign orphan_cnt = orphan_q;

endmodule

// File: tb/tb_port_rx_checker.sv
// Directed bench for port_rx_checker (PORT_ID=1, MAX_LEN=256).
// Results are collected on each pkt_done pulse and compared with hand-computed values.
// Inputs are driven 1 time unit after the rising edge; outputs sampled at the same point or on the falling edge.
module tb_port_rx_checker;

  localparam int CNT_W = 16;

  logic             sys_clk;
  logic             sys_rst;
  logic             rd_sop, rd_eop, rd_vld;
  logic [7:0]       rd_data;
  logic             clr_stats;
  logic             busy, pkt_done, pkt_ok;
  logic [3:0]       pkt_pri, pkt_dest;
  logic [11:0]      pkt_len;
  logic [4:0]       pkt_err;
  logic [CNT_W-1:0] good_cnt, bad_cnt, orphan_cnt;

  int checks = 0;
  int errors = 0;
  logic clr_on_eop = 1'b0;

  typedef struct packed {
    logic [11:0] len;
    logic [4:0]  err;
    logic [3:0]  pri;
    logic [3:0]  dest;
    logic        ok;
  } res_t;

  res_t res_q[$];
  res_t r;

  port_rx_checker #(
    .PORT_ID(1), .MIN_LEN(2), .MAX_LEN(256), .CNT_W(CNT_W), .CHECK_PATTERN(1)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .rd_sop(rd_sop), .rd_eop(rd_eop), .rd_vld(rd_vld), .rd_data(rd_data),
    .clr_stats(clr_stats),
    .busy(busy), .pkt_done(pkt_done), .pkt_ok(pkt_ok),
    .pkt_pri(pkt_pri), .pkt_dest(pkt_dest), .pkt_len(pkt_len), .pkt_err(pkt_err),
    .good_cnt(good_cnt), .bad_cnt(bad_cnt), .orphan_cnt(orphan_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Record every finished packet
  always @(negedge sys_clk) begin
    if (pkt_done) res_q.push_back('{pkt_len, pkt_err, pkt_pri, pkt_dest, pkt_ok});
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic e, input logic [7:0] d);
    rd_vld  = v;
    rd_sop  = s;
    rd_eop  = e;
    rd_data = d;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // Header plus n-1 pattern bytes; optional corrupted byte, 3-cycle gap, and eop on the last byte.
  // Returns one clock after the last beat with inputs deasserted.
  task automatic send_pkt(input logic [7:0] hdr, input int n, input int bad_idx,
                          input int gap_idx, input logic with_eop);
    logic [7:0] d;
    logic       e;
    e = with_eop && (n == 1);
    clr_stats = clr_on_eop && e;
    drive(1'b1, 1'b1, e, hdr);
    for (int k = 1; k < n; k++) begin
      if (k == gap_idx) idle(3);
      d = (k == bad_idx) ? 8'hFF : 8'(k - 1);
      e = with_eop && (k == n - 1);
      clr_stats = clr_on_eop && e;
      drive(1'b1, 1'b0, e, d);
    end
    clr_stats = 1'b0;
    rd_vld = 1'b0;
    rd_sop = 1'b0;
    rd_eop = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [11:0] len, input logic [4:0] err,
                           input logic [3:0] pri, input logic [3:0] dest);
    res_t x;
    check({tag, "_avail"}, 32'(res_q.size() > 0), 32'd1);
    if (res_q.size() > 0) begin
      x = res_q.pop_front();
      check({tag, "_len"},  32'(x.len),  32'(len));
      check({tag, "_err"},  32'(x.err),  32'(err));
      check({tag, "_pri"},  32'(x.pri),  32'(pri));
      check({tag, "_dest"}, 32'(x.dest), 32'(dest));
      check({tag, "_ok"},   32'(x.ok),   32'(err == 5'd0));
    end
  endtask

  initial begin
    sys_rst   = 1'b1;
    rd_vld    = 1'b0;
    rd_sop    = 1'b0;
    rd_eop    = 1'b0;
    rd_data   = 8'h00;
    clr_stats = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    idle(2);

    // Reset state
    check("rst_done",   32'(pkt_done),   32'd0);
    check("rst_busy",   32'(busy),       32'd0);
    check("rst_len",    32'(pkt_len),    32'd0);
    check("rst_err",    32'(pkt_err),    32'd0);
    check("rst_good",   32'(good_cnt),   32'd0);
    check("rst_bad",    32'(bad_cnt),    32'd0);
    check("rst_orphan", 32'(orphan_cnt), 32'd0);

    // 1: good 67-byte packet, 1-cycle latency
    send_pkt(8'h11, 67, -1, -1, 1'b1);
    check("t1_done_lat", 32'(pkt_done), 32'd1);
    check("t1_good",     32'(good_cnt), 32'd1);
    idle(1);
    check("t1_done_pulse", 32'(pkt_done), 32'd0);
    check("t1_ok_held",    32'(pkt_ok),   32'd1);
    pop_check("t1", 12'd67, 5'b00000, 4'd1, 4'd1);

    // 2: wrong destination
    send_pkt(8'h32, 10, -1, -1, 1'b1);
    idle(1);
    pop_check("t2", 12'd10, 5'b00001, 4'd3, 4'd2);
    check("t2_bad",  32'(bad_cnt),  32'd1);
    check("t2_good", 32'(good_cnt), 32'd1);

    // 3: corrupted byte 20, 3-cycle vld gap before byte 40
    send_pkt(8'h11, 67, 20, 40, 1'b1);
    idle(1);
    pop_check("t3", 12'd67, 5'b00010, 4'd1, 4'd1);
    check("t3_bad", 32'(bad_cnt), 32'd2);

    // 4: packet A truncated by a sop on its byte index 30; B completes normally
    send_pkt(8'h11, 30, -1, -1, 1'b0);
    check("t4_busy", 32'(busy), 32'd1);
    send_pkt(8'h21, 5, -1, -1, 1'b1);
    idle(1);
    check("t4_count", 32'(res_q.size()), 32'd2);
    pop_check("t4a", 12'd30, 5'b10000, 4'd1, 4'd1);
    pop_check("t4b", 12'd5,  5'b00000, 4'd2, 4'd1);
    check("t4_good", 32'(good_cnt), 32'd2);
    check("t4_bad",  32'(bad_cnt),  32'd3);

    // 5: 300-byte packet exceeds MAX_LEN=256 (pattern wraps)
    send_pkt(8'h11, 300, -1, -1, 1'b1);
    idle(1);
    pop_check("t5_long", 12'd256, 5'b01000, 4'd1, 4'd1);
    // single-beat sop+eop packet is short
    send_pkt(8'h11, 1, -1, -1, 1'b1);
    check("t5_busy", 32'(busy), 32'd0);
    idle(1);
    pop_check("t5_short", 12'd1, 5'b00100, 4'd1, 4'd1);
    check("t5_bad", 32'(bad_cnt), 32'd5);

    // 6: orphan beats
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, (i == 2), 8'hAA);
    idle(1);
    check("t6_orphan", 32'(orphan_cnt), 32'd5);
    check("t6_orphan_nodone", 32'(res_q.size()), 32'd0);

    // reset mid-packet
    send_pkt(8'h11, 10, -1, -1, 1'b0);
    check("t6_busy_pre", 32'(busy), 32'd1);
    sys_rst = 1'b1;
    #2;
    check("t6_rst_async_busy", 32'(busy), 32'd0);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    idle(3);
    check("t6_rst_nodone", 32'(res_q.size()), 32'd0);
    check("t6_rst_good",   32'(good_cnt),     32'd0);
    check("t6_rst_bad",    32'(bad_cnt),      32'd0);
    check("t6_rst_orphan", 32'(orphan_cnt),   32'd0);
    check("t6_rst_len",    32'(pkt_len),      32'd0);

    // clr_stats coinciding with a finishing packet
    send_pkt(8'h11, 4, -1, -1, 1'b1);
    idle(1);
    check("t6_good_pre_clr", 32'(good_cnt), 32'd1);
    clr_on_eop = 1'b1;
    send_pkt(8'h11, 4, -1, -1, 1'b1);
    clr_on_eop = 1'b0;
    check("t6_clr_done", 32'(pkt_done), 32'd1);
    check("t6_clr_good", 32'(good_cnt), 32'd0);
    idle(1);
    check("t6_clr_good_hold", 32'(good_cnt), 32'd0);
    pop_check("t6_pre", 12'd4, 5'b00000, 4'd1, 4'd1);
    pop_check("t6_clr", 12'd4, 5'b00000, 4'd1, 4'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
